tilt_stepper: RTL and testbench

TILT_STEPPER -- requirements
Module: tilt_stepper

---
 rtl/tilt_pkg.sv | 22 ++
 rtl/sample_averager.sv | 73 +++++++
 rtl/tilt_stepper.sv | 124 ++++++++++++
 tb/tb_tilt_stepper.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tilt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tilt_pkg
// Brief    : Shared tilt-stepper state type and default parameter values.
// Revision : 1.0
// ============================================================================
package tilt_pkg;

    typedef enum logic [1:0] {
        CENTER = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2
    } tilt_state_t;

    localparam int c_SAMPLE_DIV  = 1000000;
    localparam int c_AVG_LOG2    = 3;
    localparam int c_TH_ON       = 200;
    localparam int c_TH_OFF      = 120;
    localparam int c_REPEAT_AVGS = 4;

endpackage
`default_nettype wire

// File: rtl/sample_averager.sv
`default_nettype none
// ============================================================================
// Module   : sample_averager
// Brief    : Sample-rate divider and 2^AVG_LOG2 block averager for accel_x.
// Revision : 1.0
// ============================================================================
module sample_averager
    import tilt_pkg::*;
#(
    parameter int SAMPLE_DIV = c_SAMPLE_DIV,
    parameter int AVG_LOG2   = c_AVG_LOG2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [13:0]        accel_x,
    output logic signed [11:0] avg_out,
    output logic               avg_valid
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int ACC_W = 12 + AVG_LOG2;

    logic [DIV_W-1:0]        r_div;
    logic [AVG_LOG2-1:0]     r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [11:0]      r_avg;
    logic                    r_upd;
    logic                    r_valid;

    logic                    w_tick;
    logic signed [ACC_W-1:0] w_sample;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_unused_hi;

    assign w_tick      = (r_div == DIV_W'(SAMPLE_DIV - 1));
    assign w_sample    = {{AVG_LOG2{accel_x[11]}}, accel_x[11:0]};
    assign w_sum       = r_acc + w_sample;
    assign w_unused_hi = ^accel_x[13:12];

    // Upper slice of the sum is the arithmetic right shift by AVG_LOG2 (floor).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_avg   <= '0;
            r_upd   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_upd   <= 1'b0;
            r_valid <= r_upd;
            if (w_tick) begin
                r_div <= '0;
                if (&r_cnt) begin
                    r_avg <= w_sum[ACC_W-1:AVG_LOG2];
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_upd <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign avg_out   = r_avg;
    assign avg_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/tilt_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tilt_stepper
// Brief    : Tilt direction FSM with hysteresis and auto-repeat step strobes.
// Revision : 1.0
// ============================================================================
module tilt_stepper
    import tilt_pkg::*;
#(
    parameter int SAMPLE_DIV  = c_SAMPLE_DIV,
    parameter int AVG_LOG2    = c_AVG_LOG2,
    parameter int TH_ON       = c_TH_ON,
    parameter int TH_OFF      = c_TH_OFF,
    parameter int REPEAT_AVGS = c_REPEAT_AVGS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [13:0]        accel_x,
    output logic               left,
    output logic               right,
    output logic               step_left,
    output logic               step_right,
    output logic signed [11:0] avg_out,
    output logic               avg_valid
);

    localparam int REP_W = $clog2(REPEAT_AVGS + 1);

    logic signed [11:0] w_avg;
    logic               w_avg_valid;
    logic signed [31:0] w_avg_i;

    tilt_state_t        r_state;
    tilt_state_t        w_state_nxt;
    logic [REP_W-1:0]   r_rep;
    logic [REP_W-1:0]   w_rep_nxt;
    logic [REP_W-1:0]   w_rep_inc;
    logic               w_step_l_nxt;
    logic               w_step_r_nxt;
    logic               r_left;
    logic               r_right;
    logic               r_step_l;
    logic               r_step_r;

    sample_averager #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .AVG_LOG2   (AVG_LOG2)
    ) u_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .accel_x   (accel_x),
        .avg_out   (w_avg),
        .avg_valid (w_avg_valid)
    );

    assign w_avg_i   = {{20{w_avg[11]}}, w_avg};
    assign w_rep_inc = r_rep + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_rep_nxt    = r_rep;
        w_step_l_nxt = 1'b0;
        w_step_r_nxt = 1'b0;
        if (w_avg_valid) begin
            case (r_state)
                CENTER: begin
                    if (w_avg_i >= TH_ON)       w_state_nxt = RIGHT;
                    else if (w_avg_i <= -TH_ON) w_state_nxt = LEFT;
                end
                RIGHT: begin
                    if (w_avg_i <= -TH_ON)      w_state_nxt = LEFT;
                    else if (w_avg_i < TH_OFF)  w_state_nxt = CENTER;
                end
                LEFT: begin
                    if (w_avg_i >= TH_ON)       w_state_nxt = RIGHT;
                    else if (w_avg_i > -TH_OFF) w_state_nxt = CENTER;
                end
                default: w_state_nxt = CENTER;
            endcase

            // A held direction counts averages and re-fires the strobe on wrap.
            if (w_state_nxt != r_state) begin
                w_rep_nxt    = '0;
                w_step_l_nxt = (w_state_nxt == LEFT);
                w_step_r_nxt = (w_state_nxt == RIGHT);
            end else if (r_state != CENTER) begin
                if (w_rep_inc == REP_W'(REPEAT_AVGS)) begin
                    w_rep_nxt    = '0;
                    w_step_l_nxt = (r_state == LEFT);
                    w_step_r_nxt = (r_state == RIGHT);
                end else begin
                    w_rep_nxt = w_rep_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= CENTER;
            r_rep    <= '0;
            r_left   <= 1'b0;
            r_right  <= 1'b0;
            r_step_l <= 1'b0;
            r_step_r <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rep    <= w_rep_nxt;
            r_left   <= (w_state_nxt == LEFT);
            r_right  <= (w_state_nxt == RIGHT);
            r_step_l <= w_step_l_nxt;
            r_step_r <= w_step_r_nxt;
        end
    end

    assign left       = r_left;
    assign right      = r_right;
    assign step_left  = r_step_l;
    assign step_right = r_step_r;
    assign avg_out    = w_avg;
    assign avg_valid  = w_avg_valid;

endmodule
`default_nettype wire

// File: tb/tb_tilt_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_tilt_stepper
// Brief    : Self-checking bench for tilt_stepper against a per-average model.
// Revision : 1.0
// ============================================================================
module tb_tilt_stepper;

    localparam int SAMPLE_DIV  = 4;
    localparam int AVG_LOG2    = 2;
    localparam int TH_ON       = 200;
    localparam int TH_OFF      = 120;
    localparam int REPEAT_AVGS = 3;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic [13:0]        accel_x = '0;
    logic               left;
    logic               right;
    logic               step_left;
    logic               step_right;
    logic signed [11:0] avg_out;
    logic               avg_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: direction -1/0/+1, last average, held-average count.
    int m_dir, m_dir_nxt, m_step_nxt, m_rep, m_avg;
    bit m_pending, m_apply;

    always #5 clk = ~clk;

    tilt_stepper #(
        .SAMPLE_DIV  (SAMPLE_DIV),
        .AVG_LOG2    (AVG_LOG2),
        .TH_ON       (TH_ON),
        .TH_OFF      (TH_OFF),
        .REPEAT_AVGS (REPEAT_AVGS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .accel_x    (accel_x),
        .left       (left),
        .right      (right),
        .step_left  (step_left),
        .step_right (step_right),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input int e_valid, input int e_sl, input int e_sr);
        chk($sformatf("avg_valid@%0d", cyc), avg_valid, e_valid);
        chk($sformatf("avg_out@%0d", cyc), avg_out, m_avg);
        chk($sformatf("left@%0d", cyc), left, (m_dir < 0) ? 1 : 0);
        chk($sformatf("right@%0d", cyc), right, (m_dir > 0) ? 1 : 0);
        chk($sformatf("step_left@%0d", cyc), step_left, e_sl);
        chk($sformatf("step_right@%0d", cyc), step_right, e_sr);
    endtask

    function automatic int sx(input logic [13:0] raw);
        logic signed [11:0] t;
        t = raw[11:0];
        return int'(t);
    endfunction

    function automatic logic [13:0] mk(input int v, input int hi);
        return {2'(hi), 12'(v)};
    endfunction

    function automatic int floor4(input int s);
        return (s >= 0) ? (s / 4) : -((-s + 3) / 4);
    endfunction

    task automatic model_reset();
        m_dir = 0; m_dir_nxt = 0; m_step_nxt = 0; m_rep = 0; m_avg = 0;
        m_pending = 0; m_apply = 0;
    endtask

    task automatic model_decide();
        int t;
        t = (m_avg >= TH_ON) ? 1 : ((m_avg <= -TH_ON) ? -1 : 0);
        m_step_nxt = 0;
        if (m_dir == 0)              m_dir_nxt = t;
        else if (t == -m_dir)        m_dir_nxt = t;
        else if (m_dir * m_avg < TH_OFF) m_dir_nxt = 0;
        else                         m_dir_nxt = m_dir;
        if (m_dir_nxt != m_dir) begin
            m_rep      = 0;
            m_step_nxt = m_dir_nxt;
        end else if (m_dir != 0) begin
            m_rep++;
            if (m_rep == REPEAT_AVGS) begin
                m_step_nxt = m_dir;
                m_rep      = 0;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cyc = 0;
            chk_all(0, 0, 0);
        end
        rst_n = 1'b1;
    endtask

    // One averaging window of four samples, each held for one divider period.
    task automatic run_window(input logic [13:0] s0, input logic [13:0] s1,
                              input logic [13:0] s2, input logic [13:0] s3,
                              input int ncyc);
        logic [13:0] smp [4];
        int sum, e_valid, e_sl, e_sr;
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        sum = 0;
        for (int c = 1; c <= ncyc; c++) begin
            accel_x = smp[(c - 1) / 4];
            @(posedge clk); #1;
            cyc++;
            e_valid = 0; e_sl = 0; e_sr = 0;
            if (c == 1 && m_pending) begin
                e_valid   = 1;
                m_pending = 0;
                model_decide();
                m_apply = 1;
            end
            if (c == 2 && m_apply) begin
                m_dir   = m_dir_nxt;
                e_sl    = (m_step_nxt < 0) ? 1 : 0;
                e_sr    = (m_step_nxt > 0) ? 1 : 0;
                m_apply = 0;
            end
            if (c % 4 == 0) sum += sx(smp[c / 4 - 1]);
            if (c == 16) begin
                m_avg     = floor4(sum);
                m_pending = 1;
            end
            chk_all(e_valid, e_sl, e_sr);
        end
    endtask

    task automatic flat(input int v, input int n);
        for (int i = 0; i < n; i++) run_window(mk(v, 0), mk(v, 0), mk(v, 0), mk(v, 0), 16);
    endtask

    initial begin
        int base;
        logic [13:0] r [4];

        do_reset(3);

        // Entry into RIGHT at cycle 18, then auto-repeat every 48 cycles.
        flat(250, 6);
        // Hysteresis: 130 and 120 hold RIGHT, 119 drops to CENTER.
        flat(130, 1);
        flat(120, 1);
        flat(119, 1);
        flat(250, 2);
        // Direct reversal, then repeat restarts from zero in LEFT.
        flat(-200, 5);
        run_window(mk(-1, 0), mk(-1, 0), mk(-1, 0), mk(-2, 0), 16);
        run_window(14'h30FA, 14'h30FA, 14'h30FA, 14'h30FA, 16);
        flat(-120, 1);
        flat(-119, 2);

        for (int w = 0; w < 12; w++) begin
            base = int'($urandom_range(0, 700)) - 350;
            for (int k = 0; k < 4; k++)
                r[k] = mk(base + int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 3)));
            run_window(r[0], r[1], r[2], r[3], 16);
        end

        // Reset mid-average while in RIGHT; partial sum must be discarded.
        flat(250, 3);
        run_window(mk(-400, 0), mk(-400, 0), mk(-400, 0), mk(-400, 0), 6);
        do_reset(1);
        flat(250, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
